// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scanner.
package seg_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } scan_state_e;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [7:0] DATA_OFF  = {1'b1, SEG_BLANK};

   // Width of a digit index / select-position counter for n digits.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/seg_next_idx.sv
// Next enabled digit search: scans upward from cur_idx+1 with wrap; wrap flags
// that the scan came back to or below the current digit (end of a frame).
module seg_next_idx #(
   parameter int N_DIGITS = 6,
   parameter int IDX_W    = 3
) (
   input  logic [IDX_W-1:0]    cur_idx,
   input  logic [N_DIGITS-1:0] en,
   output logic [IDX_W-1:0]    nxt_idx,
   output logic                wrap
);

   logic                found;
   logic [N_DIGITS-1:0] en_sh;
   int                  j;

   always_comb begin
      nxt_idx = cur_idx;
      found   = 1'b0;
      en_sh   = '0;
      j       = 0;
      for (int k = 1; k <= N_DIGITS; k++) begin
         j = int'(cur_idx) + k;
         if (j >= N_DIGITS) j = j - N_DIGITS;
         en_sh = en >> j;
         if (!found && en_sh[0]) begin
            nxt_idx = IDX_W'(j);
            found   = 1'b1;
         end
      end
      // A lone enabled digit finds itself, which counts as a wrap.
      wrap = found && (nxt_idx <= cur_idx);
   end

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed common-anode 7-segment scanner with per-slot blanking dead time.
// Optional per-digit blink is built when SEG_SCAN_BLINK_EN is defined.
module seg_scan_mux
   import seg_pkg::*;
#(
   parameter int N_DIGITS     = 6,
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYC    = 4,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                  clk,
   input  logic                  sysclr,
   input  logic [N_DIGITS-1:0]   digit_en,
   input  logic [7*N_DIGITS-1:0] seg_in,
   input  logic [N_DIGITS-1:0]   dp_in,
   input  logic [N_DIGITS-1:0]   blink_mask,
   output logic [N_DIGITS-1:0]   SEG_SEL_n,
   output logic [7:0]            SEG_DATA,
   output logic                  frame_done
);

   localparam int IDX_W = idx_width(N_DIGITS);
   localparam int PC_W  = $clog2(SCAN_DIV);

   scan_state_e         state_q, state_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [N_DIGITS-1:0] sel_n_q, sel_n_d;
   logic [7:0]          data_q, data_d;
   logic                frame_done_q, frame_done_d;

   logic                slot_end;
   logic                show;
   logic [IDX_W-1:0]    search_from;
   logic [IDX_W-1:0]    nxt_idx;
   logic                nxt_wrap;
   logic [7*N_DIGITS-1:0] seg_sh;

   assign slot_end = (pc_q == PC_W'(SCAN_DIV - 1));

   // From IDLE, searching after the top digit yields the lowest enabled digit.
   assign search_from = (state_q == IDLE) ? IDX_W'(N_DIGITS - 1) : idx_q;

   seg_next_idx #(
      .N_DIGITS (N_DIGITS),
      .IDX_W    (IDX_W)
   ) u_next_idx (
      .cur_idx (search_from),
      .en      (digit_en),
      .nxt_idx (nxt_idx),
      .wrap    (nxt_wrap)
   );

   assign seg_sh = seg_in >> (7 * int'(idx_q));

   always_comb begin
      pc_d         = slot_end ? '0 : pc_q + 1'b1;
      state_d      = state_q;
      idx_d        = idx_q;
      sel_n_d      = '1;
      data_d       = DATA_OFF;
      frame_done_d = 1'b0;
      case (state_q)
         BLANK: begin
            if (pc_q == PC_W'(BLANK_CYC - 1)) begin
               state_d = DRIVE;
               if (show) begin
                  sel_n_d = ~(N_DIGITS'(1) << idx_q);
                  data_d  = {~dp_in[idx_q], seg_sh[6:0]};
               end
            end
         end
         DRIVE: begin
            if (slot_end) begin
               if (digit_en == '0) begin
                  state_d = IDLE;
               end else begin
                  state_d      = BLANK;
                  idx_d        = nxt_idx;
                  frame_done_d = nxt_wrap;
               end
            end else if (show) begin
               sel_n_d = ~(N_DIGITS'(1) << idx_q);
               data_d  = {~dp_in[idx_q], seg_sh[6:0]};
            end
         end
         IDLE: begin
            if (slot_end && (digit_en != '0)) begin
               state_d = BLANK;
               idx_d   = nxt_idx;
            end
         end
         default: begin
            state_d = BLANK;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge sysclr) begin
      if (sysclr) begin
         state_q      <= BLANK;
         pc_q         <= '0;
         idx_q        <= '0;
         sel_n_q      <= '1;
         data_q       <= DATA_OFF;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         idx_q        <= idx_d;
         sel_n_q      <= sel_n_d;
         data_q       <= data_d;
         frame_done_q <= frame_done_d;
      end
   end

`ifdef SEG_SCAN_BLINK_EN
   localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [FC_W-1:0] fcnt_q, fcnt_d;
   logic            phase_q, phase_d;

   // Phase advances on the same edge that launches frame_done, so a slot
   // starting a new frame already sees the new phase during its DRIVE.
   always_comb begin
      fcnt_d  = fcnt_q;
      phase_d = phase_q;
      if (frame_done_d) begin
         if (fcnt_q == FC_W'(BLINK_FRAMES - 1)) begin
            fcnt_d  = '0;
            phase_d = ~phase_q;
         end else begin
            fcnt_d  = fcnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge sysclr) begin
      if (sysclr) begin
         fcnt_q  <= '0;
         phase_q <= 1'b1;
      end else begin
         fcnt_q  <= fcnt_d;
         phase_q <= phase_d;
      end
   end

   assign show = phase_q || !blink_mask[idx_q];
`else
   localparam int unused_blink_frames = BLINK_FRAMES;
   logic unused_blink_mask;

   assign unused_blink_mask = ^blink_mask;
   assign show              = 1'b1;
`endif

   assign SEG_SEL_n  = sel_n_q;
   assign SEG_DATA   = data_q;
   assign frame_done = frame_done_q;

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
Parametrised multiplexed 7-segment scanner, the next generation of the fixed 4-digit scanner. Drives N_DIGITS common-anode digits with active-low select and data, per-digit enable and decimal point, and a blanking dead-time between digits to remove ghosting. Sits between the display encoders (floor/state/timer) and the board pins. Optional per-digit blink.

Parameters:
N_DIGITS, 6, number of digit positions (2..8)
SCAN_DIV, 50000, clk cycles per digit slot (>=4)
BLANK_CYC, 4, cycles at slot start with all selects off (1..SCAN_DIV-2)
BLINK_FRAMES, 64, full frames per blink half-period (used only with SEG_SCAN_BLINK_EN)

Ports:
clk  in  1  system clock
sysclr  in  1  asynchronous reset, active-high
digit_en  in  N_DIGITS  1 = digit participates in scan
seg_in  in  7*N_DIGITS  segment codes, active-low, digit i at [7i+6:7i]
dp_in  in  N_DIGITS  decimal point per digit, active-high
blink_mask  in  N_DIGITS  1 = digit blinks (ignored without macro)
SEG_SEL_n  out  N_DIGITS  digit select, active-low, one-cold or all ones
SEG_DATA  out  8  [7]=dp active-low, [6:0]=segments active-low
frame_done  out  1  one-cycle pulse when scan wraps to lowest enabled digit

Behaviour:
- Reset (async, sysclr=1): SEG_SEL_n all ones, SEG_DATA 8'hFF, frame_done 0, prescaler 0, idx 0, state BLANK. All outputs registered.
- Prescaler pc counts 0..SCAN_DIV-1, wraps; slot_end = (pc==SCAN_DIV-1).
- FSM states: IDLE, BLANK, DRIVE.
  - BLANK: outputs off (SEL all ones, DATA FF). At pc==BLANK_CYC-1 -> DRIVE.
  - DRIVE: SEG_SEL_n = ~(1<<idx); SEG_DATA = {~dp_in[idx], seg_in[idx]}, resampled each cycle (1-cycle latency from inputs to pins). At slot_end -> advance idx, -> BLANK.
  - IDLE: entered at slot_end when digit_en==0; outputs off, pc keeps running; leaves at a slot_end where digit_en!=0, idx = lowest enabled digit, -> BLANK.
- Advance: idx_next = next set bit of digit_en searching idx+1 upward, wrapping at N_DIGITS; if only idx enabled, idx unchanged. digit_en sampled only at slot_end; mid-slot changes do not affect current slot.
- If current idx becomes disabled mid-slot, the slot completes normally.
- frame_done: 1-cycle pulse in the cycle after slot_end when idx_next <= idx (wrap), including single-enabled-digit case; never in IDLE.
- Select and data change only while in BLANK or at BLANK->DRIVE transition; never a cycle with new select and old data.
- Reset mid-slot: immediate off, restart at pc 0, idx 0 BLANK (idx 0 driven even if disabled for first slot only, then advance rule applies).

Optional Feature:
SEG_SCAN_BLINK_EN. Defined: frame counter counts frame_done pulses; blink phase toggles every BLINK_FRAMES frames, reset phase = on. While phase off, a DRIVE slot for a digit with blink_mask[idx]=1 keeps SEG_SEL_n all ones and SEG_DATA FF; timing unchanged. Undefined: no frame counter, blink_mask ignored, digits always shown.

Decomposition:
- Shared package seg_pkg: scan state enum (IDLE/BLANK/DRIVE), SEG_BLANK=7'h7F constant, active-low digit select helper width.
- One sub-module: seg_next_idx (combinational priority search: current idx, enable mask -> next idx, wrap flag). Prescaler, FSM, blink counter stay in top.

Test Plan:
- N_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, digit_en=4'hF, seg_in distinct -> SEG_SEL_n sequence 1110,1101,1011,0111, each low for 6 cycles after 2 all-ones cycles; frame_done every 32 cycles.
- digit_en=4'b1010 -> only digits 1 and 3 selected, period 16 cycles, frame_done on each wrap to digit 1.
- digit_en=0 at slot_end -> outputs 4'hF/8'hFF held; set digit_en=4'b0100 -> next slot_end resumes at digit 2, frame_done never pulses while idle.
- dp_in=4'b0001, seg_in[0]=7'h40 -> during digit 0 DRIVE, SEG_DATA=8'h40; other digits bit7=1.
- Assert sysclr mid-DRIVE -> same-cycle outputs off asynchronously; after release, BLANK 2 cycles then digit 0.
- With SEG_SCAN_BLINK_EN, BLINK_FRAMES=2, blink_mask=4'b0001 -> digit 0 dark in frames 2-3, shown in frames 0-1 and 4-5; other digits unaffected.
